axi4_lite_write_slave: RTL and testbench
========================================

Name: axi4_lite_write_slave

Overview:
AXI4-Lite write-channel responder terminating the AW/W/B channels driven by our write master. It accepts address and data independently, in either order, and decodes the address into a bank of NUM_REGS byte-enabled registers. It then returns a single B response per transaction. Register contents are exported flat to downstream control logic, along with a one-cycle write-event strobe.

Parameters:
ADDR_WIDTH, 32, width of AW_ADDR
DATA_WIDTH, 32, width of W_DATA and each register; must be 32 or 64
NUM_REGS, 8, number of registers; power of 2, >= 2
BASE_ADDR, 32'h0000_0000, byte address of register 0; aligned to NUM_REGS*(DATA_WIDTH/8)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
AW_ADDR  in  ADDR_WIDTH  write address
AW_VALID  in  1  address valid
AW_READY  out  1  address accepted
W_DATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte enables
W_VALID  in  1  data valid
W_READY  out  1  data accepted
B_RESP  out  2  write response
B_VALID  out  1  response valid
B_READY  in  1  response accepted
reg_out  out  NUM_REGS*DATA_WIDTH  register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  out  1  one-cycle strobe, register written
wr_index  out  log2(NUM_REGS)  index written; valid with wr_pulse

Behaviour:
- Reset (synchronous, active-high) forces the following, with priority over all other activity including mid-transaction:
  - state IDLE, all registers 0, B_VALID=0, B_RESP=2'b00, wr_pulse=0, wr_index=0.
  - Any held address or data is discarded.
- States:
  - IDLE: AW_READY=1, W_READY=1.
  - HAVE_ADDR: AW_READY=0, W_READY=1.
  - HAVE_DATA: AW_READY=1, W_READY=0.
  - RESP: both READY=0, B_VALID=1.
- READY outputs decode from registered state only; they never depend combinationally on VALID inputs.
- Handshake rule: a channel transfers when VALID&&READY at a rising edge. The transferred value is captured into a holding register.
- Transitions:
  - IDLE: AW only -> HAVE_ADDR. W only -> HAVE_DATA. Both in the same cycle -> RESP.
  - HAVE_ADDR: W handshake -> RESP.
  - HAVE_DATA: AW handshake -> RESP.
  - RESP: B_READY -> IDLE. Otherwise hold RESP; B_RESP is stable while B_VALID=1.
- Completion edge (the edge where the second channel transfers):
  - Decode uses the held or live address and applies WSTRB to the held or live data.
  - The register update and B_RESP/B_VALID become visible in the cycle after the completion edge. Latency from completion to B_VALID is 1 cycle.
- Decode:
  - offset = AW_ADDR - BASE_ADDR.
  - In range iff AW_ADDR >= BASE_ADDR and offset < NUM_REGS*(DATA_WIDTH/8).
  - index = offset >> log2(DATA_WIDTH/8). Low offset bits are ignored, so unaligned addresses write the containing word.
- In range: byte k of the register is updated iff WSTRB[k]. B_RESP=OKAY (2'b00). wr_pulse=1 for exactly one cycle, coincident with the first B_VALID cycle, with wr_index=index.
- WSTRB=0 in range: no bytes change, B_RESP=OKAY, wr_pulse still asserted.
- Out of range: no register changes, B_RESP=SLVERR (2'b10), wr_pulse=0.
- One outstanding transaction only: no new AW or W is accepted until B completes. An AW or W presented during RESP waits, and is accepted in IDLE on the cycle after the B handshake.
- EXOKAY and DECERR are never generated.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the write-slave state encoding IDLE/HAVE_ADDR/HAVE_DATA/RESP (2 bits).
- The same package is usable by the write master and a future read slave.
- One natural sub-module: axi4_lite_regfile. It is a byte-enabled register bank with inputs we, index, wdata, wstrb, and output reg_out, with synchronous reset to 0. The top level holds the channel FSM, holding registers and decode.

Test Plan:
- Simultaneous AW=BASE+0x4 and W=32'hDEAD_BEEF, WSTRB=4'hF, B_READY=1 -> reg1=DEADBEEF; B_VALID for 1 cycle, 1 cycle after handshake; B_RESP=00; wr_pulse with wr_index=1.
- W first (32'h1234_5678), AW 3 cycles later at BASE+0x8 -> W_READY=0 while waiting, AW_READY=1; reg2=12345678; OKAY.
- Reg0=FFFF_FFFF, write 32'h0000_00AA with WSTRB=4'b0001 -> reg0=FFFF_FFAA; WSTRB=0 write leaves it unchanged, with OKAY and wr_pulse=1.
- AW=BASE+NUM_REGS*4 (8 regs: BASE+0x20) -> B_RESP=10; no register changed; wr_pulse=0.
- B_READY held low 5 cycles with a new AW/W presented -> B_VALID/B_RESP stable, both READY=0; second write completes only after B handshake.
- Reset asserted in HAVE_ADDR and again in RESP -> next cycle IDLE, B_VALID=0, all reg_out=0; the following write behaves normally.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions for the write master, the write slave and
// the read slave.
//   RESP_*      : B/R channel response codes
//   wr_state_t  : write-slave channel FSM encoding (2 bits)
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HAVE_ADDR = 2'd1,
    HAVE_DATA = 2'd2,
    RESP      = 2'd3
  } wr_state_t;

endpackage

// File: rtl/axi4_lite_write_slave_if.sv
// AXI4-Lite write channels (AW, W, B) between a write master and slave.
// Handshake: a channel transfers on a rising clk edge where VALID && READY.
// The source holds VALID and its payload stable until that transfer; the
// sink may raise or lower READY freely and never waits on VALID to do so.
//   master modport: drives AW_*, W_*, B_READY
//   slave modport : drives AW_READY, W_READY, B_RESP, B_VALID
interface axi4_lite_write_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   AW_ADDR;
  logic                    AW_VALID;
  logic                    AW_READY;
  logic [DATA_WIDTH-1:0]   W_DATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    W_VALID;
  logic                    W_READY;
  logic [1:0]              B_RESP;
  logic                    B_VALID;
  logic                    B_READY;

  modport master (
    output AW_ADDR, AW_VALID, W_DATA, WSTRB, W_VALID, B_READY,
    input  AW_READY, W_READY, B_RESP, B_VALID
  );

  modport slave (
    input  AW_ADDR, AW_VALID, W_DATA, WSTRB, W_VALID, B_READY,
    output AW_READY, W_READY, B_RESP, B_VALID
  );

endinterface

// File: rtl/axi4_lite_regfile.sv
// Byte-enabled register bank with synchronous active-high reset to zero.
//   clk, reset : clock / synchronous reset
//   we         : write enable for one register this cycle
//   index      : register selected for writing
//   wdata      : write data
//   wstrb      : byte k of the register is written iff wstrb[k]
//   reg_out    : all registers flattened; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
module axi4_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [$clog2(NUM_REGS)-1:0]    index,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int k = 0; k < DATA_WIDTH/8; k++) begin
        if (wstrb[k]) regs[index][k*8 +: 8] <= wdata[k*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: rtl/axi4_lite_write_slave.sv
// AXI4-Lite write responder. Accepts AW and W independently in either
// order, decodes the address into a bank of NUM_REGS registers and returns
// one B response per transaction. One transaction outstanding at a time.
//   clk, reset : clock / synchronous active-high reset
//   bus        : AW/W/B channels (slave side)
//   reg_out    : register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse   : one-cycle strobe with the first B_VALID cycle of an
//                in-range write
//   wr_index   : register index written, valid with wr_pulse
//   state_dbg  : current channel FSM state
module axi4_lite_write_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  axi4_lite_write_slave_if.slave         bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic                           wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]    wr_index,
  output wr_state_t                      state_dbg
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int LSB   = $clog2(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS*(DATA_WIDTH/8));

  wr_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic [1:0]              b_resp_q;

  logic aw_hs, w_hs, complete;
  logic [ADDR_WIDTH-1:0]   eff_addr, offset;
  logic [DATA_WIDTH-1:0]   eff_data;
  logic [DATA_WIDTH/8-1:0] eff_strb;
  logic                    in_range;
  logic [IDX_W-1:0]        index;

  assign aw_hs = bus.AW_VALID && bus.AW_READY;
  assign w_hs  = bus.W_VALID  && bus.W_READY;

  // Completion is the edge on which the second of the two channels arrives.
  assign complete = ((state_q == IDLE)      && aw_hs && w_hs) ||
                    ((state_q == HAVE_ADDR) && w_hs)          ||
                    ((state_q == HAVE_DATA) && aw_hs);

  // Whichever channel arrived earlier comes from its holding register,
  // the one completing the transaction comes straight from the bus.
  assign eff_addr = (state_q == HAVE_ADDR) ? addr_q : bus.AW_ADDR;
  assign eff_data = (state_q == HAVE_DATA) ? data_q : bus.W_DATA;
  assign eff_strb = (state_q == HAVE_DATA) ? strb_q : bus.WSTRB;

  // Low offset bits are dropped, so unaligned addresses hit the whole word.
  assign offset   = eff_addr - BASE_ADDR;
  assign in_range = (eff_addr >= BASE_ADDR) && (offset < SPAN);
  assign index    = offset[LSB +: IDX_W];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = RESP;
        else if (aw_hs)    state_d = HAVE_ADDR;
        else if (w_hs)     state_d = HAVE_DATA;
      end
      HAVE_ADDR: if (w_hs)        state_d = RESP;
      HAVE_DATA: if (aw_hs)       state_d = RESP;
      RESP:      if (bus.B_READY) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.AW_READY = 1'b0;
    bus.W_READY  = 1'b0;
    bus.B_VALID  = 1'b0;
    unique case (state_q)
      IDLE:      begin bus.AW_READY = 1'b1; bus.W_READY = 1'b1; end
      HAVE_ADDR: bus.W_READY  = 1'b1;
      HAVE_DATA: bus.AW_READY = 1'b1;
      RESP:      bus.B_VALID  = 1'b1;
      default:   ;
    endcase
  end

  assign bus.B_RESP = b_resp_q;
  assign state_dbg  = state_q;

  // Holding registers, response and write strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      b_resp_q <= RESP_OKAY;
      wr_pulse <= 1'b0;
      wr_index <= '0;
    end else begin
      if (aw_hs) addr_q <= bus.AW_ADDR;
      if (w_hs) begin
        data_q <= bus.W_DATA;
        strb_q <= bus.WSTRB;
      end
      wr_pulse <= complete && in_range;
      if (complete) begin
        b_resp_q <= in_range ? RESP_OKAY : RESP_SLVERR;
        if (in_range) wr_index <= index;
      end
    end
  end

  axi4_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (complete && in_range),
    .index   (index),
    .wdata   (eff_data),
    .wstrb   (eff_strb),
    .reg_out (reg_out)
  );

endmodule

// File: tb/tb_axi4_lite_write_slave.sv
module tb_axi4_lite_write_slave;
  import axi4_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi4_lite_write_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [NR*DW-1:0] reg_out;
  logic             wr_pulse;
  logic [2:0]       wr_index;
  wr_state_t        state_dbg;

  axi4_lite_write_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .reg_out   (reg_out),
    .wr_pulse  (wr_pulse),
    .wr_index  (wr_index),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;
  logic [DW-1:0] model [NR];
  logic [1:0]    exp_q [$];

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  task automatic check(input string tag, input logic [NR*DW-1:0] obs,
                       input logic [NR*DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // B channel: compare against the oldest expected response.
  task automatic check_b(input string tag);
    logic [1:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    check({tag, ".bvalid"}, NR*DW'(bus.B_VALID), NR*DW'(1));
    check({tag, ".bresp"},  NR*DW'(bus.B_RESP),  NR*DW'(e));
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs are then driven and outputs sampled 1 time
  // unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb);
    bus.AW_ADDR  = addr;
    bus.AW_VALID = 1'b1;
    bus.W_DATA   = data;
    bus.WSTRB    = strb;
    bus.W_VALID  = 1'b1;
    tick();
    idle_bus();
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_clear();
    bus.AW_ADDR = '0; bus.W_DATA = '0; bus.WSTRB = '0;
    idle_bus();
    bus.B_READY = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst.state",  NR*DW'(state_dbg),    NR*DW'(IDLE));
    check("rst.awrdy",  NR*DW'(bus.AW_READY), NR*DW'(1));
    check("rst.wrdy",   NR*DW'(bus.W_READY),  NR*DW'(1));
    check("rst.bvalid", NR*DW'(bus.B_VALID),  NR*DW'(0));
    check("rst.bresp",  NR*DW'(bus.B_RESP),   NR*DW'(0));
    check("rst.pulse",  NR*DW'(wr_pulse),     NR*DW'(0));
    check("rst.idx",    NR*DW'(wr_index),     NR*DW'(0));
    check("rst.regs",   reg_out,              model_flat());

    // 1: simultaneous AW/W to reg1
    do_write(32'h4, 32'hDEAD_BEEF, 4'hF);
    model[1] = 32'hDEAD_BEEF; exp_q.push_back(RESP_OKAY);
    check_b("t1");
    check("t1.pulse", NR*DW'(wr_pulse), NR*DW'(1));
    check("t1.idx",   NR*DW'(wr_index), NR*DW'(1));
    check("t1.regs",  reg_out,          model_flat());
    tick();
    check("t1.bdone",  NR*DW'(bus.B_VALID), NR*DW'(0));
    check("t1.pulse0", NR*DW'(wr_pulse),    NR*DW'(0));

    // 2: W first, AW three cycles later to reg2
    bus.W_DATA = 32'h1234_5678; bus.WSTRB = 4'hF; bus.W_VALID = 1'b1;
    tick();
    bus.W_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2.wrdy",  NR*DW'(bus.W_READY),  NR*DW'(0));
      check("t2.awrdy", NR*DW'(bus.AW_READY), NR*DW'(1));
      if (i < 2) tick();
    end
    bus.AW_ADDR = 32'h8; bus.AW_VALID = 1'b1;
    tick();
    idle_bus();
    model[2] = 32'h1234_5678; exp_q.push_back(RESP_OKAY);
    check_b("t2");
    check("t2.idx",  NR*DW'(wr_index), NR*DW'(2));
    check("t2.regs", reg_out,          model_flat());
    tick();

    // 3: byte strobes, then an empty strobe
    do_write(32'h0, 32'hFFFF_FFFF, 4'hF);
    model[0] = 32'hFFFF_FFFF; exp_q.push_back(RESP_OKAY);
    check_b("t3a");
    tick();
    do_write(32'h0, 32'h0000_00AA, 4'b0001);
    model[0] = 32'hFFFF_FFAA; exp_q.push_back(RESP_OKAY);
    check_b("t3b");
    check("t3b.regs", reg_out, model_flat());
    tick();
    do_write(32'h0, 32'h1234_5678, 4'b0000);
    exp_q.push_back(RESP_OKAY);
    check_b("t3c");
    check("t3c.pulse", NR*DW'(wr_pulse), NR*DW'(1));
    check("t3c.idx",   NR*DW'(wr_index), NR*DW'(0));
    check("t3c.regs",  reg_out,          model_flat());
    tick();

    // 4: first address past the bank
    do_write(32'h20, 32'h5555_5555, 4'hF);
    exp_q.push_back(RESP_SLVERR);
    check_b("t4");
    check("t4.pulse", NR*DW'(wr_pulse), NR*DW'(0));
    check("t4.regs",  reg_out,          model_flat());
    tick();

    // 5: B back-pressure with a second transaction waiting
    bus.B_READY = 1'b0;
    do_write(32'hC, 32'hA5A5_A5A5, 4'hF);
    model[3] = 32'hA5A5_A5A5; exp_q.push_back(RESP_OKAY);
    bus.AW_ADDR = 32'h10; bus.AW_VALID = 1'b1;
    bus.W_DATA = 32'h1111_2222; bus.WSTRB = 4'hF; bus.W_VALID = 1'b1;
    check("t5.pulse", NR*DW'(wr_pulse), NR*DW'(1));
    for (int i = 0; i < 5; i++) begin
      check("t5.bvalid", NR*DW'(bus.B_VALID),  NR*DW'(1));
      check("t5.bresp",  NR*DW'(bus.B_RESP),   NR*DW'(RESP_OKAY));
      check("t5.awrdy",  NR*DW'(bus.AW_READY), NR*DW'(0));
      check("t5.wrdy",   NR*DW'(bus.W_READY),  NR*DW'(0));
      check("t5.regs",   reg_out,              model_flat());
      tick();
      if (i > 0) check("t5.nopulse", NR*DW'(wr_pulse), NR*DW'(0));
    end
    void'(exp_q.pop_front());
    bus.B_READY = 1'b1;
    tick();
    check("t5.idle",   NR*DW'(state_dbg),    NR*DW'(IDLE));
    check("t5.awrdy1", NR*DW'(bus.AW_READY), NR*DW'(1));
    check("t5.regs1",  reg_out,              model_flat());
    tick();
    idle_bus();
    model[4] = 32'h1111_2222; exp_q.push_back(RESP_OKAY);
    check_b("t5b");
    check("t5b.idx",  NR*DW'(wr_index), NR*DW'(4));
    check("t5b.regs", reg_out,          model_flat());
    tick();

    // 6a: reset while holding an address
    bus.AW_ADDR = 32'h14; bus.AW_VALID = 1'b1;
    tick();
    idle_bus();
    check("t6a.state", NR*DW'(state_dbg), NR*DW'(HAVE_ADDR));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    check("t6a.idle",   NR*DW'(state_dbg),   NR*DW'(IDLE));
    check("t6a.bvalid", NR*DW'(bus.B_VALID), NR*DW'(0));
    check("t6a.regs",   reg_out,             model_flat());
    // Held address was discarded: W alone must only reach HAVE_DATA.
    bus.W_DATA = 32'h0000_0077; bus.WSTRB = 4'hF; bus.W_VALID = 1'b1;
    tick();
    idle_bus();
    check("t6a.hdata", NR*DW'(state_dbg), NR*DW'(HAVE_DATA));
    bus.AW_ADDR = 32'h1C; bus.AW_VALID = 1'b1;
    tick();
    idle_bus();
    model[7] = 32'h0000_0077; exp_q.push_back(RESP_OKAY);
    check_b("t6a");
    check("t6a.idx",  NR*DW'(wr_index), NR*DW'(7));
    check("t6a.wr",   reg_out,          model_flat());
    tick();

    // 6b: reset while the response is pending
    bus.B_READY = 1'b0;
    do_write(32'h18, 32'h0BAD_F00D, 4'hF);
    check("t6b.resp", NR*DW'(state_dbg), NR*DW'(RESP));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    bus.B_READY = 1'b1;
    check("t6b.idle",   NR*DW'(state_dbg),   NR*DW'(IDLE));
    check("t6b.bvalid", NR*DW'(bus.B_VALID), NR*DW'(0));
    check("t6b.bresp",  NR*DW'(bus.B_RESP),  NR*DW'(0));
    check("t6b.pulse",  NR*DW'(wr_pulse),    NR*DW'(0));
    check("t6b.regs",   reg_out,             model_flat());
    do_write(32'h4, 32'hCAFE_F00D, 4'hF);
    model[1] = 32'hCAFE_F00D; exp_q.push_back(RESP_OKAY);
    check_b("t6c");
    check("t6c.idx",  NR*DW'(wr_index), NR*DW'(1));
    check("t6c.regs", reg_out,          model_flat());
    tick();
    check("t6c.done", NR*DW'(bus.B_VALID), NR*DW'(0));

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
